// File: rtl/home_pkg.sv
// Shared definitions for the home status serial link: frame constants,
// bit-level tx FSM states and the frame byte selector.
package home_pkg;

  localparam logic [7:0] STATUS_SYNC        = 8'hA5;
  localparam int         STATUS_FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // payload is {B1, B2}; byte 3 is the XOR checksum of the first three.
  function automatic logic [7:0] status_byte(input logic [1:0]  idx,
                                             input logic [15:0] payload);
    logic [7:0] b;
    case (idx)
      2'd0:    b = STATUS_SYNC;
      2'd1:    b = payload[15:8];
      2'd2:    b = payload[7:0];
      default: b = STATUS_SYNC ^ payload[15:8] ^ payload[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/status_byte_tx.sv
// One UART byte (start, 8 data LSB first, stop), CLKS_PER_BIT cycles per bit.
// A load during the last stop-bit cycle chains the next byte with no idle gap.
module status_byte_tx
  import home_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    bit_end     = (cnt_q == CNT_MAX);
    byte_done_o = (state_q == STOP) && bit_end;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = START;
          cnt_d   = '0;
          tx_d    = 1'b0;
          shift_d = byte_i;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // shift_q[0] is the bit on the line; [1] is the next one out
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load_i) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = byte_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/home_status_tx.sv
// Sends a 4-byte home status frame (sync, status, occupants, checksum) over UART
// on input change, heartbeat expiry or force request; owns trigger, snapshot and sequencing.
module home_status_tx
  import home_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT     = 434,
  parameter int unsigned HEARTBEAT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] alarms,
  input  logic       lights_on,
  input  logic       heat_on,
  input  logic       cool_on,
  input  logic       pump_on,
  input  logic       sprink_on,
  input  logic [7:0] occupants,
  input  logic       force_send,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [31:0] HB_MAX    = 32'(HEARTBEAT_CYCLES - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(STATUS_FRAME_BYTES - 1);

  logic [15:0] live;
  logic [15:0] last_sent_q, last_sent_d;
  logic [15:0] frame_q, frame_d;
  logic [31:0] hb_q, hb_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fpend_q, fpend_d;
  logic        start, hb_expired, load, byte_done;
  logic [7:0]  load_byte;

  assign live       = {alarms, lights_on, heat_on, cool_on, pump_on, sprink_on, occupants};
  assign hb_expired = (hb_q == HB_MAX);
  assign start      = !busy_q && enable &&
                      ((live != last_sent_q) || hb_expired || fpend_q || force_send);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sent_q <= '0;
      frame_q     <= '0;
      hb_q        <= '0;
      byte_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fpend_q     <= 1'b0;
    end else begin
      last_sent_q <= last_sent_d;
      frame_q     <= frame_d;
      hb_q        <= hb_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fpend_q     <= fpend_d;
    end
  end

  always_comb begin
    last_sent_d = last_sent_q;
    frame_d     = frame_q;
    hb_d        = hb_q;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fpend_d     = fpend_q;
    load        = 1'b0;
    load_byte   = STATUS_SYNC;

    if (start) begin
      busy_d      = 1'b1;
      byte_idx_d  = 2'd0;
      frame_d     = live;
      last_sent_d = live;
      hb_d        = '0;
      fpend_d     = 1'b0;
      load        = 1'b1;
    end else begin
      fpend_d = fpend_q | force_send;
      // Saturates at expiry so a disabled link fires as soon as it is re-enabled
      if (!busy_q && !hb_expired) begin
        hb_d = hb_q + 32'd1;
      end
      if (busy_q && byte_done) begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == LAST_BYTE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          load      = 1'b1;
          load_byte = status_byte(byte_idx_q + 2'd1, frame_q);
        end
      end
    end
  end

  status_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .byte_i     (load_byte),
    .tx_o       (tx),
    .byte_done_o(byte_done)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_home_status_tx.sv
// Directed and randomized checks of home_status_tx: decodes the serial line
// bit by bit and compares each frame against payloads predicted from the driven inputs.
module tb_home_status_tx;

  localparam int CPB = 4;
  localparam int HB  = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        force_send;
  logic [15:0] live_v;
  logic        tx, busy, frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  home_status_tx #(
    .CLKS_PER_BIT    (CPB),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .alarms    (live_v[15:13]),
    .lights_on (live_v[12]),
    .heat_on   (live_v[11]),
    .cool_on   (live_v[10]),
    .pump_on   (live_v[9]),
    .sprink_on (live_v[8]),
    .occupants (live_v[7:0]),
    .force_send(force_send),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then samples every cycle of a 40-bit frame.
  // Optional hooks: change live inputs at sample chg_at, pulse force_send at sample fs_at.
  task automatic recv(input string tag, input int exp_wait, input logic [15:0] payload,
                      input int chg_at, input logic [15:0] chg_val, input int fs_at);
    logic [7:0] exp_b [4];
    logic [7:0] got [4];
    int waited, unstable, framing, busy_lo, lows, exp_lows, s;
    logic first;
    exp_b[0] = 8'hA5;
    exp_b[1] = payload[15:8];
    exp_b[2] = payload[7:0];
    exp_b[3] = exp_b[0] ^ exp_b[1] ^ exp_b[2];
    exp_lows = 4;
    for (int i = 0; i < 4; i++) exp_lows += 8 - $countones(exp_b[i]);
    waited = 0;
    while (tx !== 1'b0 && waited <= exp_wait + 4) begin
      step();
      waited++;
    end
    check({tag, "_wait"}, waited, exp_wait);
    if (tx !== 1'b0) return;
    unstable = 0; framing = 0; busy_lo = 0; lows = 0; first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got[i] = 8'h00;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < CPB; c++) begin
          s = i * 10 * CPB + j * CPB + c;
          if (c == 0) first = tx;
          else if (tx !== first) unstable++;
          if (tx === 1'b0) lows++;
          if (busy !== 1'b1) busy_lo++;
          if (c == 0) begin
            if (j == 0 && tx !== 1'b0) framing++;
            if (j == 9 && tx !== 1'b1) framing++;
            if (j >= 1 && j <= 8) got[i][j-1] = tx;
          end
          if (s == chg_at) live_v = chg_val;
          if (s == fs_at) force_send = 1'b1;
          else if (s == fs_at + 1) force_send = 1'b0;
          step();
        end
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s_byte%0d", tag, i), got[i], exp_b[i]);
    check({tag, "_bit_stable"}, unstable, 0);
    check({tag, "_framing"}, framing, 0);
    check({tag, "_busy_during"}, busy_lo, 0);
    check({tag, "_low_cycles"}, lows, exp_lows * CPB);
    check({tag, "_frame_done"}, frame_done, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] r1, r2, nv, sent, nv5, nv6;
    int bad, cnt;

    reset      = 1'b1;
    enable     = 1'b1;
    force_send = 1'b0;
    live_v     = {3'b100, 1'b1, 4'b0000, 8'h03};
    step();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    step();
    reset = 1'b0;

    // Live inputs differ from the cleared snapshot: immediate frame.
    recv("t1", 1, 16'h9003, -1, 16'h0, -1);
    // Static inputs: only the heartbeat resends.
    recv("t2_hb", HB, 16'h9003, -1, 16'h0, -1);

    // force_send in idle starts on the same edge; mid-frame change is deferred.
    force_send = 1'b1;
    step();
    force_send = 1'b0;
    recv("t3_cur", 0, 16'h9003, 40, 16'h9004, -1);
    recv("t3_next", 1, 16'h9004, -1, 16'h0, -1);

    // Force while busy plus an input change: one follow-up frame only.
    r1 = 16'($urandom);
    if (r1 == 16'h9004) r1 = ~r1;
    r2 = 16'($urandom);
    if (r2 == r1) r2 = ~r1;
    live_v = r1;
    recv("t4_a", 1, r1, 50, r2, 60);
    recv("t4_follow", 1, r2, -1, 16'h0, -1);
    recv("t4_hb", HB, r2, -1, 16'h0, -1);
    sent = r2;

    for (int k = 0; k < 6; k++) begin
      nv = 16'($urandom);
      live_v = nv;
      recv($sformatf("rnd%0d", k), (nv != sent) ? 1 : HB, nv, -1, 16'h0, -1);
      sent = nv;
    end

    // Disabled: line stays idle through heartbeat expiry and a force request.
    nv5 = sent ^ 16'hE000;
    enable = 1'b0;
    live_v = nv5;
    bad = 0;
    for (int c = 0; c < 450; c++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      if (c == 10) force_send = 1'b1;
      else if (c == 11) force_send = 1'b0;
    end
    check("t5_disabled_idle", bad, 0);
    enable = 1'b1;
    recv("t5_enable", 1, nv5, -1, 16'h0, -1);
    recv("t5_hb", HB, nv5, -1, 16'h0, -1);
    sent = nv5;

    // Reset in the middle of byte 2 aborts at once.
    nv6 = sent ^ 16'h00FF;
    if (nv6 == 16'h0000) nv6 = 16'h0001;
    live_v = nv6;
    cnt = 0;
    while (tx !== 1'b0 && cnt < 8) begin
      step();
      cnt++;
    end
    check("t6_start", cnt, 1);
    repeat (90) step();
    check("t6_busy_mid", busy, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_tx", tx, 1'b1);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", frame_done, 1'b0);
    step();
    step();
    reset = 1'b0;
    recv("t6_after", 1, nv6, -1, 16'h0, -1);
    step();
    check("done_pulse_width", frame_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
